// File: rtl/rs5_halfword_fetch_aligner_pkg.sv
// ---------------------------------------------------------------------------
// rs5_halfword_fetch_aligner_pkg
//   Shared types and helpers for the halfword fetch aligner.
//   - fetch_state_e : fetch FSM states (BOOT issues the first read, RUN
//                     presents instructions)
//   - INSTR_C_SIZE / INSTR_SIZE : byte sizes of 16-bit and 32-bit encodings
//   - is_compressed : true when the low halfword starts a 16-bit encoding
// ---------------------------------------------------------------------------
package rs5_halfword_fetch_aligner_pkg;

   typedef enum logic [0:0] {FETCH_BOOT, FETCH_RUN} fetch_state_e;

   localparam int INSTR_C_SIZE = 2;
   localparam int INSTR_SIZE   = 4;

   // 32-bit encodings are the only ones with both low opcode bits set.
   function automatic logic is_compressed(input logic [15:0] lo);
      return (lo[1:0] != 2'b11);
   endfunction

endpackage

// File: rtl/rs5_halfword_fetch_aligner_assembler.sv
// ---------------------------------------------------------------------------
// rs5_halfword_fetch_aligner_assembler
//   Purely combinational instruction assembler. Takes the halfword at the
//   PC (lo) and the following halfword (hi) and produces the instruction
//   word, its compressed flag and its size in bytes. Kept separate so a
//   future prefetch buffer can reuse it.
//   Ports:
//     lo_i         in  16  halfword at PC
//     hi_i         in  16  halfword at PC+2
//     instr_o      out 32  assembled instruction (upper half 0 if compressed)
//     compressed_o out 1   lo_i begins a 16-bit encoding
//     size_o       out 3   instruction size in bytes (2 or 4)
// ---------------------------------------------------------------------------
module rs5_halfword_fetch_aligner_assembler
   import rs5_halfword_fetch_aligner_pkg::*;
(
   input  logic [15:0] lo_i,
   input  logic [15:0] hi_i,
   output logic [31:0] instr_o,
   output logic        compressed_o,
   output logic [2:0]  size_o
);

   always_comb begin
      compressed_o = is_compressed(lo_i);
      if (compressed_o) begin
         instr_o = {16'h0000, lo_i};
         size_o  = 3'(INSTR_C_SIZE);
      end else begin
         instr_o = {hi_i, lo_i};
         size_o  = 3'(INSTR_SIZE);
      end
   end

endmodule

// File: rtl/rs5_halfword_fetch_aligner.sv
// ---------------------------------------------------------------------------
// rs5_halfword_fetch_aligner
//   Fetch front end for a 16-bit-word dual-read instruction RAM. Each read
//   returns RAM[addr] and RAM[addr+1] one cycle later, so any halfword
//   aligned PC yields a full 32-bit window and no misalignment bubble.
//   Delivers up to one instruction per cycle over valid/ready, with jump
//   redirect.
//
//   Handshake: an instruction transfers on a cycle where valid_o & ready_i
//   and jump_i is low. While valid_o & ~ready_i the RAM is not enabled, so
//   its held outputs keep instr_o/pc_o/compressed_o stable. jump_i in RUN
//   discards the presented instruction whatever ready_i is.
//
//   Optional feature: define RS5_FETCH_WRAP_FAULT_EN to raise fault_o for a
//   32-bit instruction whose upper half lies past the last RAM word. When
//   undefined, fault_o is tied 0.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     mem_en_o        RAM read enable
//     mem_addr_o      RAM halfword address (PC[ADDR_WIDTH:1] of the fetch)
//     mem_data_a_i    RAM[addr]   (bits [15:0] used)
//     mem_data_b_i    RAM[addr+1] (bits [15:0] used)
//     jump_i          redirect request
//     jump_target_i   redirect byte PC (bit 0 forced 0)
//     instr_o         assembled instruction
//     pc_o            byte PC of instr_o
//     compressed_o    instr_o is a 16-bit encoding
//     valid_o         instruction outputs valid
//     ready_i         decode accepts
//     fault_o         wrap fault
//     state_o         debug view of the fetch FSM state
// ---------------------------------------------------------------------------
module rs5_halfword_fetch_aligner
   import rs5_halfword_fetch_aligner_pkg::*;
#(
   parameter int          ADDR_WIDTH = 16,
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [31:0]           mem_data_a_i,
   input  logic [31:0]           mem_data_b_i,
   input  logic                  jump_i,
   input  logic [31:0]           jump_target_i,
   output logic [31:0]           instr_o,
   output logic [31:0]           pc_o,
   output logic                  compressed_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  fault_o,
   output fetch_state_e          state_o
);

   localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:1], 1'b0};

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;

   logic [31:0]  asm_instr;
   logic         asm_compressed;
   logic [2:0]   asm_size;
   logic [31:0]  pc_next;
   logic [31:0]  fetch_pc;
   logic         fetch_en;

   // Upper RAM bus bits and jump target bit 0 carry nothing we use.
   logic unused_bits;
   assign unused_bits = ^{mem_data_a_i[31:16], mem_data_b_i[31:16], jump_target_i[0]};

   rs5_halfword_fetch_aligner_assembler u_assembler (
      .lo_i         (mem_data_a_i[15:0]),
      .hi_i         (mem_data_b_i[15:0]),
      .instr_o      (asm_instr),
      .compressed_o (asm_compressed),
      .size_o       (asm_size)
   );

   // Full 32-bit wrap; only PC[ADDR_WIDTH:1] reaches the RAM.
   assign pc_next = pc_q + {29'b0, asm_size};

   // The RAM output registers hold data for pc_q in RUN, so valid follows
   // the state directly. rst gates it so a mid-stream reset cycle shows
   // reset values immediately.
   assign valid_o = (state_q == FETCH_RUN) && !rst;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fetch_en = 1'b0;
      fetch_pc = pc_q;
      case (state_q)
         FETCH_BOOT: begin
            fetch_en = 1'b1;
            fetch_pc = BOOT_PC;
            pc_d     = BOOT_PC;
            state_d  = FETCH_RUN;
         end
         FETCH_RUN: begin
            if (jump_i) begin
               fetch_en = 1'b1;
               fetch_pc = {jump_target_i[31:1], 1'b0};
               pc_d     = fetch_pc;
            end else if (ready_i) begin
               fetch_en = 1'b1;
               fetch_pc = pc_next;
               pc_d     = pc_next;
            end
         end
         default: begin
            state_d = FETCH_BOOT;
         end
      endcase
   end

   // Address path is combinational from the RAM data via the size decode;
   // this is the known critical path of the block.
   assign mem_en_o   = fetch_en && !rst;
   assign mem_addr_o = fetch_pc[ADDR_WIDTH:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_BOOT;
         pc_q    <= BOOT_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign instr_o      = valid_o ? asm_instr : 32'h0;
   assign pc_o         = valid_o ? pc_q      : 32'h0;
   assign compressed_o = valid_o && asm_compressed;
   assign state_o      = state_q;

`ifdef RS5_FETCH_WRAP_FAULT_EN
   // The RAM returns 0 for the halfword past the last word, so a 32-bit
   // instruction starting there is incomplete.
   assign fault_o = valid_o && !asm_compressed &&
                    (pc_q[ADDR_WIDTH:1] == {ADDR_WIDTH{1'b1}});
`else
   assign fault_o = 1'b0;
`endif

endmodule
